onehot_sequencer: RTL and testbench
===================================

// Module: onehot_sequencer
// PURPOSE
//  Parametrised, registered successor to the combinational 4-to-16 enable decoder.
//  Holds an index register, decodes it to a one-hot bus and can load, step up/down with wrap, or clear.
//  Used as a select/strobe sequencer (channel select, scan ring) in downstream datapaths.
// PARAMETERS
//  WIDTH       4              index width in bits
//  OUTS        1<<WIDTH       number of one-hot outputs; 2 <= OUTS <= 2**WIDTH
//  ACTIVE_LOW  0              1: one_hot inverted (active bit 0, inactive bits 1)
// PORTS
//  clk      in   1      clock, all state updates on rising edge
//  rst      in   1      synchronous, active-high reset
//  en       in   1      output enable; 0 forces one_hot inactive and freezes stepping
//  clr      in   1      return to IDLE (index kept)
//  load     in   1      load index from binary
//  binary   in   WIDTH  index to load
//  step     in   1      advance index by one
//  dir      in   1      step direction: 1 up, 0 down
//  one_hot  out  OUTS   registered decoded index
//  index    out  WIDTH  current index register
//  valid    out  1      1 when state ACTIVE and en=1 (one_hot carries an asserted bit)
//  wrap     out  1      one-cycle pulse on step wrap-around
//  err      out  1      one-cycle pulse on out-of-range load
// BEHAVIOUR
//  Reset: state=IDLE, index=0, valid=0, wrap=0, err=0, one_hot all inactive
//   (all 0, or all 1 if ACTIVE_LOW). rst overrides every other input.
//  States: IDLE (no bit asserted), ACTIVE (bit[index] asserted when en=1).
//  Command priority per cycle: rst > clr > load > step.
//  clr: ACTIVE/IDLE -> IDLE; index unchanged; load/step that cycle ignored.
//  load: binary < OUTS -> index=binary, state=ACTIVE, regardless of en.
//   binary >= OUTS -> err=1 next cycle; index and state unchanged.
//  step: acts only when state=ACTIVE, en=1, no load/clr.
//   up: index==OUTS-1 -> 0 with wrap=1, else index+1.
//   down: index==0 -> OUTS-1 with wrap=1, else index-1.
//   step in IDLE or with en=0: ignored, no wrap.
//  en=0: one_hot inactive, valid=0, state and index held; en back to 1
//   restores bit[index] on the next edge.
//  Latency: all outputs registered; command at edge N visible after edge N.
//  one_hot active only if state=ACTIVE and en=1; exactly one bit asserted,
//   the bit at index; all others inactive.
//  wrap and err are single-cycle pulses, 0 otherwise; never both set.
//  Index arithmetic is modulo OUTS, never 2**WIDTH, for non-power-of-two OUTS.
// TESTING
//  1 rst=1 two cycles, then en=1 idle -> one_hot=16'h0000, valid=0, index=0.
//  2 en=1 load binary=3 -> next cycle one_hot=16'h0008, valid=1; en=0 ->
//    one_hot=0, valid=0; en=1 -> 16'h0008.
//  3 load 15, step dir=1 -> one_hot=16'h0001, index=0, wrap=1 one cycle;
//    step dir=0 -> index=15, wrap=1.
//  4 OUTS=10: load 12 -> err=1, state unchanged.
//    load 9, step up -> index=0, wrap=1.
//  5 Same cycle clr+load+step -> IDLE, one_hot=0; load+step -> load wins.
//  6 ACTIVE_LOW=1: load 3 -> one_hot=16'hFFF7.
//    Mid-sequence rst -> 16'hFFFF, index=0.

Source files
------------

// File: rtl/onehot_sequencer.sv
// Registered one-hot select sequencer. An index register is decoded to a
// one-hot bus. The index can be loaded, stepped up or down with wrap modulo
// OUTS, or the sequencer can be cleared back to idle.
module onehot_sequencer #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned OUTS       = 1 << WIDTH,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] binary,
  input  logic             step,
  input  logic             dir,
  output logic [OUTS-1:0]  one_hot,
  output logic [WIDTH-1:0] index,
  output logic             valid,
  output logic             wrap,
  output logic             err
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  // OUTS may equal 2**WIDTH, so the range check needs one extra bit.
  localparam logic [WIDTH:0]   OutsW    = (WIDTH + 1)'(OUTS);
  localparam logic [WIDTH-1:0] MaxIdx   = WIDTH'(OUTS - 1);
  localparam logic [OUTS-1:0]  Inactive = {OUTS{ACTIVE_LOW}};

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  index_q, index_d;
  logic [OUTS-1:0]   one_hot_q, one_hot_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;
  logic [OUTS-1:0]   dec;
  logic              in_range;

  assign in_range = ({1'b0, binary} < OutsW);

  // Next-state: command priority clr > load > step; outputs precomputed from next state.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    dec     = '0;

    if (clr) begin
      state_d = StIdle;
    end else if (load) begin
      if (in_range) begin
        index_d = binary;
        state_d = StActive;
      end else begin
        err_d = 1'b1;
      end
    end else if (step && (state_q == StActive) && en) begin
      if (dir) begin
        if (index_q == MaxIdx) begin
          index_d = '0;
          wrap_d  = 1'b1;
        end else begin
          index_d = index_q + WIDTH'(1);
        end
      end else begin
        if (index_q == '0) begin
          index_d = MaxIdx;
          wrap_d  = 1'b1;
        end else begin
          index_d = index_q - WIDTH'(1);
        end
      end
    end

    valid_d = (state_d == StActive) && en;

    for (int i = 0; i < OUTS; i++) begin
      dec[i] = (index_d == WIDTH'(i));
    end
    one_hot_d = valid_d ? (dec ^ Inactive) : Inactive;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      index_q   <= '0;
      one_hot_q <= Inactive;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      one_hot_q <= one_hot_d;
      valid_q   <= valid_d;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
    end
  end

  assign one_hot = one_hot_q;
  assign index   = index_q;
  assign valid   = valid_q;
  assign wrap    = wrap_q;
  assign err     = err_q;

endmodule

// File: tb/tb_onehot_sequencer.sv
// Directed bench for onehot_sequencer: default, OUTS=10 and ACTIVE_LOW
// instances share one stimulus stream; expectations are hand-computed.
module tb_onehot_sequencer;

  logic       clk = 1'b0;
  logic       rst, en, clr, load, step, dir;
  logic [3:0] binary;

  logic [15:0] d_one_hot;
  logic [3:0]  d_index;
  logic        d_valid, d_wrap, d_err;
  logic [9:0]  t_one_hot;
  logic [3:0]  t_index;
  logic        t_valid, t_wrap, t_err;
  logic [15:0] a_one_hot;
  logic [3:0]  a_index;
  logic        a_valid, a_wrap, a_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onehot_sequencer u_dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .binary(binary),
    .step(step), .dir(dir), .one_hot(d_one_hot), .index(d_index),
    .valid(d_valid), .wrap(d_wrap), .err(d_err)
  );

  onehot_sequencer #(.WIDTH(4), .OUTS(10), .ACTIVE_LOW(1'b0)) u_dut10 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .binary(binary),
    .step(step), .dir(dir), .one_hot(t_one_hot), .index(t_index),
    .valid(t_valid), .wrap(t_wrap), .err(t_err)
  );

  onehot_sequencer #(.WIDTH(4), .OUTS(16), .ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .binary(binary),
    .step(step), .dir(dir), .one_hot(a_one_hot), .index(a_index),
    .valid(a_valid), .wrap(a_wrap), .err(a_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1ns after the rising edge.
  task automatic cyc(input logic r, input logic e, input logic c, input logic l,
                     input logic [3:0] b, input logic s, input logic d);
    rst = r; en = e; clr = c; load = l; binary = b; step = s; dir = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset, then idle with en=1
    cyc(1, 0, 0, 0, 4'd0, 0, 0);
    cyc(1, 0, 0, 0, 4'd0, 0, 0);
    chk("rst_onehot", 32'(d_one_hot), 32'h0000);
    chk("rst_index",  32'(d_index),   32'd0);
    chk("rst_valid",  32'(d_valid),   32'd0);
    chk("rst_wrap",   32'(d_wrap),    32'd0);
    chk("rst_err",    32'(d_err),     32'd0);
    chk("rst_al_onehot", 32'(a_one_hot), 32'hFFFF);
    cyc(0, 1, 0, 0, 4'd0, 0, 0);
    chk("idle_onehot", 32'(d_one_hot), 32'h0000);
    chk("idle_valid",  32'(d_valid),   32'd0);

    // 2: load 3, toggle en
    cyc(0, 1, 0, 1, 4'd3, 0, 0);
    chk("load3_onehot", 32'(d_one_hot), 32'h0008);
    chk("load3_valid",  32'(d_valid),   32'd1);
    chk("load3_index",  32'(d_index),   32'd3);
    chk("load3_al_onehot", 32'(a_one_hot), 32'hFFF7);
    chk("load3_t_onehot", 32'(t_one_hot), 32'h008);
    cyc(0, 0, 0, 0, 4'd0, 0, 0);
    chk("en0_onehot", 32'(d_one_hot), 32'h0000);
    chk("en0_valid",  32'(d_valid),   32'd0);
    chk("en0_index",  32'(d_index),   32'd3);
    chk("en0_al_onehot", 32'(a_one_hot), 32'hFFFF);
    cyc(0, 1, 0, 0, 4'd0, 0, 0);
    chk("en1_onehot", 32'(d_one_hot), 32'h0008);
    chk("en1_valid",  32'(d_valid),   32'd1);

    // 3: load 15 then wrap up and down
    cyc(0, 1, 0, 1, 4'd15, 0, 0);
    chk("load15_onehot", 32'(d_one_hot), 32'h8000);
    chk("load15_err",    32'(d_err),     32'd0);
    chk("t_load15_err",  32'(t_err),     32'd1);
    chk("t_load15_index", 32'(t_index),  32'd3);
    chk("t_load15_onehot", 32'(t_one_hot), 32'h008);
    cyc(0, 1, 0, 0, 4'd0, 1, 1);
    chk("wrapup_onehot", 32'(d_one_hot), 32'h0001);
    chk("wrapup_index",  32'(d_index),   32'd0);
    chk("wrapup_wrap",   32'(d_wrap),    32'd1);
    chk("t_stepup_index", 32'(t_index),  32'd4);
    chk("t_stepup_err",  32'(t_err),     32'd0);
    cyc(0, 1, 0, 0, 4'd0, 0, 0);
    chk("wrap_pulse_end", 32'(d_wrap),   32'd0);
    chk("hold_onehot",   32'(d_one_hot), 32'h0001);
    cyc(0, 1, 0, 0, 4'd0, 1, 0);
    chk("wrapdn_index",  32'(d_index),   32'd15);
    chk("wrapdn_wrap",   32'(d_wrap),    32'd1);
    chk("wrapdn_onehot", 32'(d_one_hot), 32'h8000);
    chk("t_stepdn_index", 32'(t_index),  32'd3);

    // 4: OUTS=10 range and modulo behaviour
    cyc(0, 1, 0, 1, 4'd12, 0, 0);
    chk("t_load12_err",   32'(t_err),     32'd1);
    chk("t_load12_index", 32'(t_index),   32'd3);
    chk("t_load12_valid", 32'(t_valid),   32'd1);
    chk("t_load12_onehot", 32'(t_one_hot), 32'h008);
    chk("load12_index",   32'(d_index),   32'd12);
    chk("load12_onehot",  32'(d_one_hot), 32'h1000);
    cyc(0, 1, 0, 0, 4'd0, 0, 0);
    chk("t_err_pulse_end", 32'(t_err),    32'd0);
    cyc(0, 1, 0, 1, 4'd9, 0, 0);
    chk("t_load9_index",  32'(t_index),   32'd9);
    chk("t_load9_onehot", 32'(t_one_hot), 32'h200);
    cyc(0, 1, 0, 0, 4'd0, 1, 1);
    chk("t_wrapup_index", 32'(t_index),   32'd0);
    chk("t_wrapup_wrap",  32'(t_wrap),    32'd1);
    chk("t_wrapup_onehot", 32'(t_one_hot), 32'h001);
    chk("d_step10_index", 32'(d_index),   32'd10);
    chk("d_step10_wrap",  32'(d_wrap),    32'd0);
    cyc(0, 1, 0, 0, 4'd0, 1, 0);
    chk("t_wrapdn_index", 32'(t_index),   32'd9);
    chk("t_wrapdn_wrap",  32'(t_wrap),    32'd1);
    chk("d_step9_index",  32'(d_index),   32'd9);

    // 5: priority and ignored steps
    cyc(0, 1, 1, 1, 4'd5, 1, 1);
    chk("clr_onehot", 32'(d_one_hot), 32'h0000);
    chk("clr_valid",  32'(d_valid),   32'd0);
    chk("clr_index",  32'(d_index),   32'd9);
    cyc(0, 1, 0, 0, 4'd0, 1, 1);
    chk("idle_step_index", 32'(d_index), 32'd9);
    chk("idle_step_wrap",  32'(d_wrap),  32'd0);
    chk("idle_step_onehot", 32'(d_one_hot), 32'h0000);
    cyc(0, 1, 0, 1, 4'd5, 1, 1);
    chk("loadstep_index",  32'(d_index),   32'd5);
    chk("loadstep_onehot", 32'(d_one_hot), 32'h0020);
    chk("loadstep_valid",  32'(d_valid),   32'd1);
    cyc(0, 0, 0, 0, 4'd0, 1, 1);
    chk("en0_step_index",  32'(d_index),   32'd5);
    chk("en0_step_onehot", 32'(d_one_hot), 32'h0000);
    chk("en0_step_wrap",   32'(d_wrap),    32'd0);
    cyc(0, 1, 0, 0, 4'd0, 0, 0);
    chk("restore_onehot",  32'(d_one_hot), 32'h0020);
    cyc(0, 0, 0, 1, 4'd2, 0, 0);
    chk("load_en0_index",  32'(d_index),   32'd2);
    chk("load_en0_onehot", 32'(d_one_hot), 32'h0000);
    chk("load_en0_valid",  32'(d_valid),   32'd0);
    cyc(0, 1, 0, 0, 4'd0, 0, 0);
    chk("load_en1_onehot", 32'(d_one_hot), 32'h0004);
    chk("load_en1_valid",  32'(d_valid),   32'd1);
    chk("al_idx2_onehot",  32'(a_one_hot), 32'hFFFB);

    // 6: mid-sequence reset overrides a load
    cyc(1, 1, 0, 1, 4'd7, 0, 0);
    chk("midrst_al_onehot", 32'(a_one_hot), 32'hFFFF);
    chk("midrst_al_index",  32'(a_index),   32'd0);
    chk("midrst_onehot",    32'(d_one_hot), 32'h0000);
    chk("midrst_valid",     32'(d_valid),   32'd0);
    cyc(0, 1, 0, 0, 4'd0, 1, 1);
    chk("postrst_index",  32'(d_index),   32'd0);
    chk("postrst_onehot", 32'(d_one_hot), 32'h0000);
    chk("postrst_wrap",   32'(d_wrap),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
